nim_move_engine: RTL and testbench
==================================

// Module: nim_move_engine
// PURPOSE
//  Consumer side of the pile-value memories: takes the stored pile counts at game start,
//  then applies player removal moves to working copies of those counts.
//  - Validates each move, alternates turns and detects end of game (normal play: taking the last stone wins).
//  - Sits between the pile memories and the display/scoring logic.
// PARAMETERS
//  NUM_PILES  4  number of piles; sel_pile width = $clog2(NUM_PILES)
//  PILE_W     4  bits per pile count
// PORTS
//  clk        in   1                    clock, rising edge
//  reset      in   1                    synchronous, active-high
//  start      in   1                    level; rising edge (re)starts a game
//  pile_init  in   NUM_PILES*PILE_W     pile i = [i*PILE_W +: PILE_W], from pile memories
//  sel_pile   in   $clog2(NUM_PILES)    pile targeted by the move
//  take_amt   in   PILE_W               stones to remove
//  take       in   1                    level; rising edge submits move
//  piles      out  NUM_PILES*PILE_W     current pile counts, same packing
//  player     out  1                    side to move: 0 = P0, 1 = P1
//  ready      out  1                    1 while state == PLAY
//  move_err   out  1                    last submitted move was illegal
//  game_over  out  1                    game finished
//  winner     out  1                    valid when game_over=1
// BEHAVIOUR
//  Reset: state=IDLE; piles=0, player=0, move_err=0, game_over=0, winner=0.
//  Edge detect: start_d/take_d sample their inputs every cycle, including during reset.
//   A button held through reset therefore produces no edge.
//   start_rise = start & ~start_d; take_rise = take & ~take_d.
//  FSM IDLE, LOAD, PLAY, CHECK, OVER (one transition per clk):
//   IDLE : start_rise -> LOAD.
//   LOAD : piles<=pile_init, player<=0, move_err<=0, game_over<=0.
//          If pile_init is all zero: -> OVER, game_over<=1, winner<=1 (P0 cannot move).
//          Otherwise -> PLAY.
//   PLAY : start_rise -> LOAD (restart; has priority over take_rise in the same cycle).
//          take_rise with a legal move -> pile[sel]<=pile[sel]-take_amt, move_err<=0, go to CHECK.
//          Legal means: sel_pile<NUM_PILES, take_amt!=0, take_amt<=pile[sel].
//          take_rise with an illegal move -> move_err<=1, piles and player unchanged, stay in PLAY.
//   CHECK: all piles zero -> OVER, game_over<=1, winner<=player (the mover).
//          Otherwise -> player<=~player, go to PLAY.
//   OVER : all outputs hold; start_rise -> LOAD.
//  take_rise outside PLAY is ignored (dropped, not queued). start_rise in CHECK is ignored.
//  Latency: take_rise sampled at edge N -> piles updated after N.
//   player toggle / game_over visible after edge N+1; ready low for exactly that one cycle (CHECK).
//  Arithmetic: unsigned PILE_W subtraction; the legality check guarantees no underflow.
//  pile_init is sampled only in LOAD; changes to it at any other time have no effect.
//  Reset mid-game: next cycle is the full reset state; game progress is discarded.
// STRUCTURE
//  nim_pkg: state_t enum {IDLE,LOAD,PLAY,CHECK,OVER}, default NUM_PILES/PILE_W localparams.
//  Sub-module rise_edge_det (clk, in, rise; delay reg, no reset), instanced for start and take.
//  Piles are held internally as an unpacked array logic [PILE_W-1:0] p[NUM_PILES], packed onto the piles output.
// TESTING
//  1. Hold start=1 through reset, release reset -> state stays IDLE, no LOAD.
//  2. pile_init={4'd3,4'd5,4'd0,4'd7} (p3..p0), start edge, then move sel=0, amt=7:
//     -> one cycle after the take edge p0=0; one cycle later player=1, ready=1.
//  3. Illegal moves: amt=0; amt=9 with pile=5; sel=1 when p1=0
//     -> move_err=1, piles and player unchanged. A following legal move clears move_err.
//  4. Play to exhaustion, P1 taking the last stone -> game_over=1, winner=1, ready=0.
//     A further take edge in OVER changes nothing.
//  5. pile_init all zero, start edge -> game_over=1, winner=1 two cycles after the edge.
//  6. start and take rising in the same PLAY cycle -> restart wins: piles=pile_init, player=0, no move applied.
//     Assert reset mid-PLAY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/nim_pkg.sv
// Shared types and default sizing for the Nim move engine.
package nim_pkg;

    localparam int DEF_NUM_PILES = 4;
    localparam int DEF_PILE_W    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        OVER  = 3'd4
    } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a level input. The delay register has no reset, so a
// level held high through reset is already "seen" and produces no edge.
module rise_edge_det (
    input  logic clk,
    input  logic in,
    output logic rise
);

    logic in_d;

    // One-cycle delayed copy of the input, sampled every cycle.
    always_ff @(posedge clk) begin
        in_d <= in;
    end

    assign rise = in & ~in_d;

endmodule

// File: rtl/nim_move_engine.sv
// Nim game engine: loads pile counts at game start, validates and applies
// removal moves, alternates turns and detects the end of game (last stone wins).
module nim_move_engine
    import nim_pkg::*;
#(
    parameter int NUM_PILES = DEF_NUM_PILES,
    parameter int PILE_W    = DEF_PILE_W,
    localparam int SEL_W    = (NUM_PILES > 1) ? $clog2(NUM_PILES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_PILES*PILE_W-1:0] pile_init,
    input  logic [SEL_W-1:0]            sel_pile,
    input  logic [PILE_W-1:0]           take_amt,
    input  logic                        take,
    output logic [NUM_PILES*PILE_W-1:0] piles,
    output logic                        player,
    output logic                        ready,
    output logic                        move_err,
    output logic                        game_over,
    output logic                        winner
);

    state_t            state, state_nx;
    logic [PILE_W-1:0] p [NUM_PILES];

    logic              start_rise, take_rise;
    logic              init_zero, piles_zero;
    logic              sel_ok, move_ok;
    logic [PILE_W-1:0] sel_cnt;

    rise_edge_det u_start_det (.clk(clk), .in(start), .rise(start_rise));
    rise_edge_det u_take_det  (.clk(clk), .in(take),  .rise(take_rise));

    // An out-of-range selector is only possible when NUM_PILES is not a power of two.
    generate
        if ((1 << SEL_W) > NUM_PILES) begin : g_sel_chk
            assign sel_ok = (32'(sel_pile) < NUM_PILES);
        end else begin : g_sel_all
            assign sel_ok = 1'b1;
        end
    endgenerate

    // Move legality and end-of-game conditions derived from the working piles.
    always_comb begin
        init_zero  = (pile_init == '0);
        piles_zero = 1'b1;
        sel_cnt    = '0;
        for (int i = 0; i < NUM_PILES; i++) begin
            if (p[i] != '0)
                piles_zero = 1'b0;
            if (32'(sel_pile) == i)
                sel_cnt = p[i];
        end
        move_ok = sel_ok && (take_amt != '0) && (take_amt <= sel_cnt);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; a restart outranks a move submitted in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start_rise) state_nx = LOAD;
            LOAD:  state_nx = init_zero ? OVER : PLAY;
            PLAY: begin
                if (start_rise)
                    state_nx = LOAD;
                else if (take_rise && move_ok)
                    state_nx = CHECK;
            end
            CHECK: state_nx = piles_zero ? OVER : PLAY;
            OVER:  if (start_rise) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Moves are only accepted while playing.
    always_comb begin
        ready = (state == PLAY);
    end

    // Working pile copies, turn and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PILES; i++)
                p[i] <= '0;
            player    <= 1'b0;
            move_err  <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    for (int i = 0; i < NUM_PILES; i++)
                        p[i] <= pile_init[i*PILE_W +: PILE_W];
                    player    <= 1'b0;
                    move_err  <= 1'b0;
                    game_over <= 1'b0;
                    // Empty board: P0 has no move, so P1 wins outright.
                    if (init_zero) begin
                        game_over <= 1'b1;
                        winner    <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!start_rise && take_rise) begin
                        if (move_ok) begin
                            for (int i = 0; i < NUM_PILES; i++)
                                if (32'(sel_pile) == i)
                                    p[i] <= p[i] - take_amt;
                            move_err <= 1'b0;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // The player who just moved took the last stone.
                    if (piles_zero) begin
                        game_over <= 1'b1;
                        winner    <= player;
                    end else begin
                        player <= ~player;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack the working copies onto the output bus.
    generate
        for (genvar g = 0; g < NUM_PILES; g++) begin : g_pack
            assign piles[g*PILE_W +: PILE_W] = p[g];
        end
    endgenerate

endmodule

// File: tb/tb_nim_move_engine.sv
// Scoreboard bench for nim_move_engine: stimulus updates a game-level model and
// queues expected output snapshots tagged with the cycle they must appear in;
// a monitor compares each snapshot on the falling edge of that cycle.
module tb_nim_move_engine;

    logic        clk = 1'b0;
    logic        reset, start, take;
    logic [15:0] pile_init;
    logic [1:0]  sel_pile;
    logic [3:0]  take_amt;
    logic [15:0] piles;
    logic        player, ready, move_err, game_over, winner;

    nim_move_engine #(.NUM_PILES(4), .PILE_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pile_init(pile_init),
        .sel_pile(sel_pile), .take_amt(take_amt), .take(take),
        .piles(piles), .player(player), .ready(ready), .move_err(move_err),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] piles;
        logic        player, ready, err, over, win;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    // Game-level model: mode 0 = waiting for start, 1 = playing, 2 = finished.
    int m_p[4];
    bit m_player, m_err, m_over, m_win;
    int m_mode;

    function automatic logic [15:0] m_pack();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'(m_p[i]);
        return v;
    endfunction

    function automatic bit m_all_zero();
        for (int i = 0; i < 4; i++) if (m_p[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int c, input string nm, input bit rdy);
        exp_t e;
        e.cyc = c; e.name = nm; e.piles = m_pack(); e.player = m_player;
        e.ready = rdy; e.err = m_err; e.over = m_over; e.win = m_win;
        q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_p[i] = 0;
        m_player = 0; m_err = 0; m_over = 0; m_win = 0; m_mode = 0;
    endtask

    // Monitor: compare every snapshot due in this cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || piles !== e.piles || player !== e.player ||
                ready !== e.ready || move_err !== e.err ||
                game_over !== e.over || winner !== e.win) begin
                failures++;
                $display("FAIL %s @cyc%0d: got piles=%h player=%b ready=%b err=%b over=%b win=%b, want piles=%h player=%b ready=%b err=%b over=%b win=%b",
                         e.name, cyc, piles, player, ready, move_err, game_over, winner,
                         e.piles, e.player, e.ready, e.err, e.over, e.win);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [15:0] init, input bit with_take,
                              input int sel, input int amt, input string nm);
        pile_init = init;
        start     = 1'b1;
        if (with_take) begin
            sel_pile = 2'(sel); take_amt = 4'(amt); take = 1'b1;
        end
        push(cyc + 1, {nm, "_load"}, 1'b0);
        for (int i = 0; i < 4; i++) m_p[i] = int'(init[i*4 +: 4]);
        m_player = 0; m_err = 0; m_over = 0;
        if (init == 16'h0) begin
            m_over = 1; m_win = 1; m_mode = 2;
        end else begin
            m_mode = 1;
        end
        push(cyc + 2, nm, m_mode == 1);
        tick();
        start = 1'b0;
        take  = 1'b0;
        tick();
        pile_init = 16'($urandom);
    endtask

    task automatic do_move(input int sel, input int amt, input string nm);
        sel_pile = 2'(sel);
        take_amt = 4'(amt);
        take     = 1'b1;
        if (m_mode == 1) begin
            if (amt != 0 && amt <= m_p[sel]) begin
                m_p[sel] -= amt;
                m_err = 0;
                push(cyc + 1, {nm, "_apply"}, 1'b0);
                if (m_all_zero()) begin
                    m_over = 1; m_win = m_player; m_mode = 2;
                end else begin
                    m_player = ~m_player;
                end
                push(cyc + 2, {nm, "_turn"}, m_mode == 1);
            end else begin
                m_err = 1;
                push(cyc + 1, {nm, "_illegal"}, 1'b1);
                push(cyc + 2, {nm, "_hold"}, 1'b1);
            end
        end else begin
            push(cyc + 1, {nm, "_ignored"}, 1'b0);
            push(cyc + 2, {nm, "_ignored2"}, 1'b0);
        end
        tick();
        take = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b1; take = 1'b0;
        pile_init = 16'h1234; sel_pile = '0; take_amt = '0;
        model_reset();
        tick();
        tick();
        tick();
        // Start held through reset must not start a game.
        reset = 1'b0;
        push(cyc, "reset_state", 1'b0);
        push(cyc + 1, "held_start_idle1", 1'b0);
        push(cyc + 2, "held_start_idle2", 1'b0);
        tick();
        tick();
        start = 1'b0;
        tick();

        // Basic load and first move.
        start_game(16'h3507, 1'b0, 0, 0, "load_3507");
        do_move(0, 7, "p0_take7");
        // Illegal moves leave everything but move_err untouched.
        do_move(3, 0, "amt_zero");
        do_move(2, 9, "amt_over");
        do_move(1, 1, "empty_pile");
        do_move(2, 5, "legal_clears_err");

        // P1 takes the last stone; takes after game over are ignored.
        start_game(16'h0002, 1'b0, 0, 0, "load_0002");
        do_move(0, 1, "p0_take1");
        do_move(0, 1, "p1_take_last");
        do_move(0, 1, "take_in_over");

        // All-zero board ends immediately with P1 winning.
        start_game(16'h0000, 1'b0, 0, 0, "load_zero");

        // Restart and move in the same cycle: restart wins.
        start_game(16'h4444, 1'b0, 0, 0, "load_4444");
        do_move(1, 2, "pre_restart_move");
        start_game(16'h1111, 1'b1, 0, 1, "restart_vs_take");

        // Reset mid-game discards progress.
        do_move(2, 1, "pre_reset_move");
        reset = 1'b1;
        model_reset();
        push(cyc + 1, "mid_reset", 1'b0);
        tick();
        reset = 1'b0;
        push(cyc + 1, "post_reset_idle", 1'b0);
        tick();
        do_move(0, 1, "take_in_idle");

        // Random games against the model.
        for (int g = 0; g < 12; g++) begin
            logic [15:0] init;
            init = 16'($urandom);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) init[i*4 +: 4] = 4'h0;
            start_game(init, 1'b0, 0, 0, "rnd_load");
            for (int m = 0; m < 40 && m_mode == 1; m++) begin
                int s, a;
                s = int'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0 && m_p[s] > 0)
                    a = int'($urandom_range(1, m_p[s]));
                else
                    a = int'($urandom_range(0, 15));
                if ($urandom_range(0, 29) == 0)
                    start_game(16'($urandom), 1'b1, s, a, "rnd_restart");
                else
                    do_move(s, a, "rnd_move");
            end
            do_move(int'($urandom_range(0, 3)), 1, "rnd_after");
        end

        tick();
        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
